// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives instruction memory and
// fills the IF/ID register under stall, flush, redirect, halt and fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt_req,
    output logic [31:0]      imem_pc,
    input  logic [31:0]      imem_instruction,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      pc_plus4;
    logic             bubble;

    assign pc_plus4 = pc_q + PC_STEP;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;

        unique case (state_q)
            BOOT: begin
                bubble  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    bubble  = 1'b1;
                    state_d = HALT;
                end else if (redirect_valid && (redirect_pc[1:0] == 2'b00)) begin
                    // Redirect overrides stall: the wrong-path fetch is dropped.
                    bubble = 1'b1;
                    pc_d   = redirect_pc;
                end else if (redirect_valid) begin
                    bubble  = 1'b1;
                    fault_d = 1'b1;
                    state_d = HALT;
                end else if (flush) begin
                    bubble = 1'b1;
                    if (!stall) begin
                        pc_d = pc_plus4;
                    end
                end else if (!stall) begin
                    instr_d = imem_instruction;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                bubble  = 1'b1;
                state_d = BOOT;
            end
        endcase

        if (bubble) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_pc        = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign halted         = (state_q == HALT);
    assign fault          = fault_q;
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl with a behavioural instruction memory.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, redirect_valid, halt_req;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc, imem_instruction;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, halted, fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        halted;
        logic        fault;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_pc[9:2]];

    fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .CNT_W   (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt_req        (halt_req),
        .imem_pc         (imem_pc),
        .imem_instruction(imem_instruction),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected IF/ID contents for a valid fetch from byte address a.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    task automatic push(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic valid, input logic [31:0] pc, input logic [31:0] cnt,
                        input logic h, input logic f);
        exp_t e;
        e.tag = tag; e.instr = instr; e.pc4 = pc4; e.valid = valid;
        e.pc = pc; e.cnt = cnt; e.halted = h; e.fault = f;
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".instr"},  if_id_instr,            e.instr);
        chk({e.tag, ".pc4"},    if_id_pc_plus4,         e.pc4);
        chk({e.tag, ".valid"},  {31'd0, if_id_valid},   {31'd0, e.valid});
        chk({e.tag, ".pc"},     imem_pc,                e.pc);
        chk({e.tag, ".cnt"},    fetch_count,            e.cnt);
        chk({e.tag, ".halted"}, {31'd0, halted},        {31'd0, e.halted});
        chk({e.tag, ".fault"},  {31'd0, fault},         {31'd0, e.fault});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        observe();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'h0000_0000;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; halt_req = 1'b0;

        push("reset", 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // BOOT bubble, then sequential fetch
        push("boot",   32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        step();
        push("fetch0", 32'h2008_0001, 32'h4, 1'b1, 32'h4, 1, 1'b0, 1'b0);
        step();
        push("fetch1", 32'h2009_0002, 32'h8, 1'b1, 32'h8, 2, 1'b0, 1'b0);
        step();

        stall = 1'b1;
        push("stall_a", 32'h2009_0002, 32'h8, 1'b1, 32'h8, 2, 1'b0, 1'b0);
        step();
        push("stall_b", 32'h2009_0002, 32'h8, 1'b1, 32'h8, 2, 1'b0, 1'b0);
        step();
        stall = 1'b0;
        push("resume", 32'h0109_5020, 32'hC, 1'b1, 32'hC, 3, 1'b0, 1'b0);
        step();

        // Redirect wins over stall
        redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        push("redir_bubble", 32'h0, 32'h0, 1'b0, 32'h40, 3, 1'b0, 1'b0);
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        push("redir_target", word_at(32'h40), 32'h44, 1'b1, 32'h44, 4, 1'b0, 1'b0);
        step();

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        push("wrap_bubble", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC, 4, 1'b0, 1'b0);
        step();
        redirect_valid = 1'b0;
        push("wrap_fetch", word_at(32'hFFFF_FFFC), 32'h0, 1'b1, 32'h0, 5, 1'b0, 1'b0);
        step();

        flush = 1'b1;
        push("flush", 32'h0, 32'h0, 1'b0, 32'h4, 5, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        push("after_flush", word_at(32'h4), 32'h8, 1'b1, 32'h8, 6, 1'b0, 1'b0);
        step();

        flush = 1'b1; stall = 1'b1;
        push("flush_stall", 32'h0, 32'h0, 1'b0, 32'h8, 6, 1'b0, 1'b0);
        step();
        flush = 1'b0; stall = 1'b0;
        push("after_fs", word_at(32'h8), 32'hC, 1'b1, 32'hC, 7, 1'b0, 1'b0);
        step();

        // Misaligned target faults and halts; later redirects ignored
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        push("misalign", 32'h0, 32'h0, 1'b0, 32'hC, 7, 1'b1, 1'b1);
        step();
        redirect_pc = 32'h80;
        push("ignored_redir", 32'h0, 32'h0, 1'b0, 32'hC, 7, 1'b1, 1'b1);
        step();
        redirect_valid = 1'b0;

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        push("async_rst", 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        observe();
        @(posedge clk);
        #1 rst = 1'b0;
        push("boot2", 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        step();
        push("refetch0", 32'h2008_0001, 32'h4, 1'b1, 32'h4, 1, 1'b0, 1'b0);
        step();

        halt_req = 1'b1;
        push("halt", 32'h0, 32'h0, 1'b0, 32'h4, 1, 1'b1, 1'b0);
        step();
        halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stall = i[0]; flush = i[1]; redirect_valid = i[2]; redirect_pc = 32'h100;
            push("halt_hold", 32'h0, 32'h0, 1'b0, 32'h4, 1, 1'b1, 1'b0);
            step();
        end
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;

        if (sb.size() != 0) chk("scoreboard_residue", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
